// File: rtl/enet_tx_reg_bank_mq.sv
// ENET MAC multi-queue TX register bank (tx_clk domain).
// Immediate registers: station address, opcode/pause, per-queue ring base, TDAR.
// Frame-affecting config is double-buffered and committed only while tx_idle.

// Per-queue state: ring base (locked while active), TDAR bit, buffered TFWR.
module enet_tx_q_lane (
  input  logic        tx_clk,
  input  logic        rst_n,
  input  logic        tx_idle,
  input  logic        wr_tdsr,
  input  logic        wr_tfwr,
  input  logic        set_tdar,
  input  logic        clr_tdar,
  input  logic [31:0] wdata,
  output logic [31:0] tdsr,
  output logic        strfwd,
  output logic [7:0]  tfwr,
  output logic        tdar,
  output logic        pend
);
  logic [28:0] base_q, base_d;
  logic        tdar_q, tdar_d;
  logic [5:0]  tfwr_p_q, tfwr_p_d;   // {strfwd, watermark[4:0]} pending
  logic [5:0]  tfwr_a_q, tfwr_a_d;   // same layout, active
  logic        tfwr_f_q, tfwr_f_d;

  // Next-state: base is locked by the pre-update TDAR; set beats clear;
  // commit uses the pending copy as it stood before this cycle's write.
  always_comb begin
    base_d   = base_q;
    tdar_d   = tdar_q;
    tfwr_p_d = tfwr_p_q;
    tfwr_a_d = (tx_idle && tfwr_f_q) ? tfwr_p_q : tfwr_a_q;
    tfwr_f_d = tfwr_f_q && !tx_idle;
    if (wr_tdsr && !tdar_q) base_d = wdata[31:3];
    if (clr_tdar) tdar_d = 1'b0;
    if (set_tdar) tdar_d = 1'b1;
    if (wr_tfwr) begin
      tfwr_p_d = {wdata[8], wdata[4:0]};
      tfwr_f_d = 1'b1;
    end
  end

  // Lane state registers with synchronous reset.
  always_ff @(posedge tx_clk) begin
    if (!rst_n) begin
      base_q   <= '0;
      tdar_q   <= 1'b0;
      tfwr_p_q <= '0;
      tfwr_a_q <= '0;
      tfwr_f_q <= 1'b0;
    end else begin
      base_q   <= base_d;
      tdar_q   <= tdar_d;
      tfwr_p_q <= tfwr_p_d;
      tfwr_a_q <= tfwr_a_d;
      tfwr_f_q <= tfwr_f_d;
    end
  end

  assign tdsr   = {base_q, 3'b000};
  assign strfwd = tfwr_a_q[5];
  assign tfwr   = {tfwr_a_q[4:0], 3'b000};
  assign tdar   = tdar_q;
  assign pend   = tfwr_f_q;
endmodule

module enet_tx_reg_bank_mq #(
  parameter int NUM_Q  = 3,
  parameter int QSEL_W = 2
) (
  input  logic                  tx_clk,
  input  logic                  rst_n,
  input  logic                  reg_wen,
  input  logic [3:0]            reg_widx,
  input  logic [QSEL_W-1:0]     reg_qsel,
  input  logic [31:0]           reg_wdata,
  input  logic                  tx_idle,
  input  logic [NUM_Q-1:0]      tdar_clr,
  output logic [31:0]           palr,
  output logic [31:0]           paur,
  output logic [31:0]           opd,
  output logic [NUM_Q*32-1:0]   tdsr,
  output logic [NUM_Q-1:0]      strfwd,
  output logic [NUM_Q*8-1:0]    tfwr,
  output logic [7:0]            tsem,
  output logic [7:0]            tafl,
  output logic [7:0]            taem,
  output logic [15:0]           tipg,
  output logic [NUM_Q-1:0]      tdar,
  output logic                  cfg_pending
);
  localparam logic [3:0] IDX_PALR = 4'd0, IDX_PAUR = 4'd1, IDX_OPD  = 4'd2,
                         IDX_TDSR = 4'd3, IDX_TFWR = 4'd4, IDX_TSEM = 4'd5,
                         IDX_TAFL = 4'd6, IDX_TAEM = 4'd7, IDX_TIPG = 4'd8,
                         IDX_TDAR = 4'd9;

  logic [31:0] palr_q, palr_d;
  logic [15:0] paur_q, paur_d;
  logic [15:0] opd_q,  opd_d;

  // Global buffered fields: pending copy (_p), active copy (_a), flag (_f).
  logic [7:0] tsem_p_q, tsem_p_d, tsem_a_q, tsem_a_d;
  logic [7:0] tafl_p_q, tafl_p_d, tafl_a_q, tafl_a_d;
  logic [7:0] taem_p_q, taem_p_d, taem_a_q, taem_a_d;
  logic [4:0] tipg_p_q, tipg_p_d, tipg_a_q, tipg_a_d;
  logic       tsem_f_q, tsem_f_d, tafl_f_q, tafl_f_d;
  logic       taem_f_q, taem_f_d, tipg_f_q, tipg_f_d;

  logic [NUM_Q-1:0] lane_pend;

  // Per-queue lanes; a select >= NUM_Q matches no lane so the write is dropped.
  for (genvar g = 0; g < NUM_Q; g++) begin : g_q
    logic hit;
    assign hit = reg_wen && (reg_qsel == QSEL_W'(g));
    enet_tx_q_lane u_lane (
      .tx_clk   (tx_clk),
      .rst_n    (rst_n),
      .tx_idle  (tx_idle),
      .wr_tdsr  (hit && (reg_widx == IDX_TDSR)),
      .wr_tfwr  (hit && (reg_widx == IDX_TFWR)),
      .set_tdar (hit && (reg_widx == IDX_TDAR)),
      .clr_tdar (tdar_clr[g]),
      .wdata    (reg_wdata),
      .tdsr     (tdsr[g*32 +: 32]),
      .strfwd   (strfwd[g]),
      .tfwr     (tfwr[g*8 +: 8]),
      .tdar     (tdar[g]),
      .pend     (lane_pend[g])
    );
  end

  // Decode global writes and commit pending fields on idle cycles.
  always_comb begin
    palr_d   = palr_q;
    paur_d   = paur_q;
    opd_d    = opd_q;
    tsem_p_d = tsem_p_q;
    tafl_p_d = tafl_p_q;
    taem_p_d = taem_p_q;
    tipg_p_d = tipg_p_q;
    tsem_a_d = (tx_idle && tsem_f_q) ? tsem_p_q : tsem_a_q;
    tafl_a_d = (tx_idle && tafl_f_q) ? tafl_p_q : tafl_a_q;
    taem_a_d = (tx_idle && taem_f_q) ? taem_p_q : taem_a_q;
    tipg_a_d = (tx_idle && tipg_f_q) ? tipg_p_q : tipg_a_q;
    tsem_f_d = tsem_f_q && !tx_idle;
    tafl_f_d = tafl_f_q && !tx_idle;
    taem_f_d = taem_f_q && !tx_idle;
    tipg_f_d = tipg_f_q && !tx_idle;
    if (reg_wen) begin
      case (reg_widx)
        IDX_PALR: palr_d = reg_wdata;
        IDX_PAUR: paur_d = reg_wdata[31:16];
        IDX_OPD:  opd_d  = reg_wdata[15:0];
        IDX_TSEM: begin
          tsem_p_d = reg_wdata[7:0];
          tsem_f_d = 1'b1;
        end
        IDX_TAFL: begin
          tafl_p_d = (reg_wdata[7:0] > 8'd240) ? 8'd240 : reg_wdata[7:0];
          tafl_f_d = 1'b1;
        end
        IDX_TAEM: begin
          taem_p_d = (reg_wdata[7:0] < 8'd4) ? 8'd4 : reg_wdata[7:0];
          taem_f_d = 1'b1;
        end
        IDX_TIPG: begin
          tipg_p_d = reg_wdata[4:0];
          tipg_f_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Global state registers; reset restores active values and clears pending.
  always_ff @(posedge tx_clk) begin
    if (!rst_n) begin
      palr_q   <= '0;
      paur_q   <= '0;
      opd_q    <= '0;
      tsem_p_q <= 8'd0;   tsem_a_q <= 8'd0;
      tafl_p_q <= 8'd240; tafl_a_q <= 8'd240;
      taem_p_q <= 8'd4;   taem_a_q <= 8'd4;
      tipg_p_q <= 5'd12;  tipg_a_q <= 5'd12;
      tsem_f_q <= 1'b0;   tafl_f_q <= 1'b0;
      taem_f_q <= 1'b0;   tipg_f_q <= 1'b0;
    end else begin
      palr_q   <= palr_d;
      paur_q   <= paur_d;
      opd_q    <= opd_d;
      tsem_p_q <= tsem_p_d; tsem_a_q <= tsem_a_d;
      tafl_p_q <= tafl_p_d; tafl_a_q <= tafl_a_d;
      taem_p_q <= taem_p_d; taem_a_q <= taem_a_d;
      tipg_p_q <= tipg_p_d; tipg_a_q <= tipg_a_d;
      tsem_f_q <= tsem_f_d; tafl_f_q <= tafl_f_d;
      taem_f_q <= taem_f_d; tipg_f_q <= tipg_f_d;
    end
  end

  assign palr        = palr_q;
  assign paur        = {paur_q, 16'h8808};
  assign opd         = {16'h0001, opd_q};
  assign tsem        = tsem_a_q;
  assign tafl        = tafl_a_q;
  assign taem        = taem_a_q;
  // Out-of-range gaps fall back to the standard 12 byte-times.
  assign tipg        = ((tipg_a_q > 5'd26) || (tipg_a_q < 5'd8)) ? 16'd12 : {11'b0, tipg_a_q};
  assign cfg_pending = (|lane_pend) | tsem_f_q | tafl_f_q | taem_f_q | tipg_f_q;
endmodule

// File: tb/tb_enet_tx_reg_bank_mq.sv
// Self-checking bench for enet_tx_reg_bank_mq with a field-level reference model.
module tb_enet_tx_reg_bank_mq;
  localparam int NQ = 3;

  logic              tx_clk = 1'b0;
  logic              rst_n;
  logic              reg_wen;
  logic [3:0]        reg_widx;
  logic [1:0]        reg_qsel;
  logic [31:0]       reg_wdata;
  logic              tx_idle;
  logic [NQ-1:0]     tdar_clr;
  logic [31:0]       palr, paur, opd;
  logic [NQ*32-1:0]  tdsr;
  logic [NQ-1:0]     strfwd;
  logic [NQ*8-1:0]   tfwr;
  logic [7:0]        tsem, tafl, taem;
  logic [15:0]       tipg;
  logic [NQ-1:0]     tdar;
  logic              cfg_pending;

  int n_tests = 0;
  int n_fail  = 0;

  enet_tx_reg_bank_mq #(.NUM_Q(NQ), .QSEL_W(2)) dut (
    .tx_clk(tx_clk), .rst_n(rst_n), .reg_wen(reg_wen), .reg_widx(reg_widx),
    .reg_qsel(reg_qsel), .reg_wdata(reg_wdata), .tx_idle(tx_idle), .tdar_clr(tdar_clr),
    .palr(palr), .paur(paur), .opd(opd), .tdsr(tdsr), .strfwd(strfwd), .tfwr(tfwr),
    .tsem(tsem), .tafl(tafl), .taem(taem), .tipg(tipg), .tdar(tdar),
    .cfg_pending(cfg_pending)
  );

  always #5 tx_clk = ~tx_clk;

  // Reference model. Global buffered fields indexed 0 TSEM, 1 TAFL, 2 TAEM, 3 TIPG(5-bit).
  logic [31:0] m_palr;
  logic [15:0] m_paur, m_opd;
  logic [31:0] m_base [NQ];
  bit          m_tdar [NQ];
  bit          m_sf_a [NQ], m_sf_p [NQ], m_tf_f [NQ];
  logic [4:0]  m_wm_a [NQ], m_wm_p [NQ];
  logic [7:0]  m_a [4], m_p [4];
  bit          m_f [4];

  task automatic model_reset();
    m_palr = '0; m_paur = '0; m_opd = '0;
    for (int i = 0; i < NQ; i++) begin
      m_base[i] = '0; m_tdar[i] = 0; m_sf_a[i] = 0; m_sf_p[i] = 0;
      m_tf_f[i] = 0; m_wm_a[i] = '0; m_wm_p[i] = '0;
    end
    m_a[0] = 8'd0; m_a[1] = 8'd240; m_a[2] = 8'd4; m_a[3] = 8'd12;
    for (int f = 0; f < 4; f++) begin m_p[f] = m_a[f]; m_f[f] = 0; end
  endtask

  // Drive one cycle of inputs, advance the model by the same cycle, sample #1 after the edge.
  task automatic cyc(input bit wen, input logic [3:0] idx, input logic [1:0] q,
                     input logic [31:0] d, input bit idle, input logic [NQ-1:0] clr);
    bit old_tdar [NQ];
    reg_wen = wen; reg_widx = idx; reg_qsel = q; reg_wdata = d;
    tx_idle = idle; tdar_clr = clr;
    if (!rst_n) model_reset();
    else begin
      if (idle) begin
        for (int f = 0; f < 4; f++) if (m_f[f]) begin m_a[f] = m_p[f]; m_f[f] = 0; end
        for (int i = 0; i < NQ; i++) if (m_tf_f[i]) begin
          m_sf_a[i] = m_sf_p[i]; m_wm_a[i] = m_wm_p[i]; m_tf_f[i] = 0;
        end
      end
      old_tdar = m_tdar;
      for (int i = 0; i < NQ; i++) if (clr[i]) m_tdar[i] = 0;
      if (wen) begin
        case (idx)
          4'd0: m_palr = d;
          4'd1: m_paur = d[31:16];
          4'd2: m_opd  = d[15:0];
          4'd3: if (q < NQ && !old_tdar[q]) m_base[q] = {d[31:3], 3'b000};
          4'd4: if (q < NQ) begin m_sf_p[q] = d[8]; m_wm_p[q] = d[4:0]; m_tf_f[q] = 1; end
          4'd5: begin m_p[0] = d[7:0]; m_f[0] = 1; end
          4'd6: begin m_p[1] = (d[7:0] > 240) ? 8'd240 : d[7:0]; m_f[1] = 1; end
          4'd7: begin m_p[2] = (d[7:0] < 4) ? 8'd4 : d[7:0]; m_f[2] = 1; end
          4'd8: begin m_p[3] = {3'b000, d[4:0]}; m_f[3] = 1; end
          4'd9: if (q < NQ) m_tdar[q] = 1;
          default: ;
        endcase
      end
    end
    @(posedge tx_clk); #1;
  endtask

  task automatic idle_cycles(input int n, input bit idle);
    for (int i = 0; i < n; i++) cyc(0, 4'd0, 2'd0, 32'd0, idle, '0);
  endtask

  function automatic logic [15:0] exp_tipg();
    return (m_a[3] > 26 || m_a[3] < 8) ? 16'd12 : {8'd0, m_a[3]};
  endfunction
  function automatic logic [NQ*32-1:0] exp_tdsr();
    logic [NQ*32-1:0] v;
    for (int i = 0; i < NQ; i++) v[i*32 +: 32] = m_base[i];
    return v;
  endfunction
  function automatic logic [NQ*8-1:0] exp_tfwr();
    logic [NQ*8-1:0] v;
    for (int i = 0; i < NQ; i++) v[i*8 +: 8] = {m_wm_a[i], 3'b000};
    return v;
  endfunction
  function automatic logic [NQ-1:0] exp_sf();
    logic [NQ-1:0] v;
    for (int i = 0; i < NQ; i++) v[i] = m_sf_a[i];
    return v;
  endfunction
  function automatic logic [NQ-1:0] exp_tdar();
    logic [NQ-1:0] v;
    for (int i = 0; i < NQ; i++) v[i] = m_tdar[i];
    return v;
  endfunction
  function automatic bit exp_pend();
    bit p = 0;
    for (int f = 0; f < 4; f++) p |= m_f[f];
    for (int i = 0; i < NQ; i++) p |= m_tf_f[i];
    return p;
  endfunction

  // Reset with a write on the same cycle; reset must win.
  task automatic test_reset();
    rst_n = 0;
    cyc(1, 4'd0, 2'd0, 32'hFFFF_FFFF, 1, '0);
    cyc(1, 4'd9, 2'd0, 32'h0, 1, '0);
    rst_n = 1;
    n_tests++; if (palr !== 32'h0) begin n_fail++; $display("FAIL reset_palr got %h want 0", palr); end
    n_tests++; if (paur !== 32'h0000_8808) begin n_fail++; $display("FAIL reset_paur got %h want 00008808", paur); end
    n_tests++; if (opd !== 32'h0001_0000) begin n_fail++; $display("FAIL reset_opd got %h want 00010000", opd); end
    n_tests++; if (tdsr !== '0 || tfwr !== '0 || strfwd !== '0 || tdar !== '0) begin
      n_fail++; $display("FAIL reset_queues tdsr %h tfwr %h sf %b tdar %b want all 0", tdsr, tfwr, strfwd, tdar); end
    n_tests++; if (tsem !== 8'd0 || tafl !== 8'd240 || taem !== 8'd4 || tipg !== 16'd12) begin
      n_fail++; $display("FAIL reset_cfg tsem %0d tafl %0d taem %0d tipg %0d want 0/240/4/12", tsem, tafl, taem, tipg); end
    n_tests++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b want 0", cfg_pending); end
  endtask

  // Clamp on entry, hold while busy, commit on idle, 2-cycle latency with idle held.
  task automatic test_buffered();
    cyc(1, 4'd6, 2'd0, 32'hFF, 0, '0);
    cyc(1, 4'd7, 2'd0, 32'h02, 0, '0);
    cyc(1, 4'd8, 2'd0, 32'h1F, 0, '0);
    cyc(1, 4'd5, 2'd0, 32'h33, 0, '0);
    n_tests++; if (tafl !== 8'd240 || taem !== 8'd4 || tipg !== 16'd12 || tsem !== 8'd0) begin
      n_fail++; $display("FAIL buf_hold tafl %0d taem %0d tipg %0d tsem %0d want 240/4/12/0", tafl, taem, tipg, tsem); end
    n_tests++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL buf_pending got %b want 1", cfg_pending); end
    idle_cycles(1, 1);
    n_tests++; if (tafl !== 8'd240 || taem !== 8'd4 || tipg !== 16'd12 || tsem !== 8'h33) begin
      n_fail++; $display("FAIL buf_commit tafl %0d taem %0d tipg %0d tsem %h want 240/4/12/33", tafl, taem, tipg, tsem); end
    n_tests++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL buf_pending_clr got %b want 0", cfg_pending); end
    cyc(1, 4'd8, 2'd0, 32'd20, 1, '0);
    n_tests++; if (tipg !== 16'd12 || cfg_pending !== 1'b1) begin
      n_fail++; $display("FAIL tipg_lat1 tipg %0d pend %b want 12/1", tipg, cfg_pending); end
    idle_cycles(1, 1);
    n_tests++; if (tipg !== 16'd20 || cfg_pending !== 1'b0) begin
      n_fail++; $display("FAIL tipg_lat2 tipg %0d pend %b want 20/0", tipg, cfg_pending); end
    cyc(1, 4'd6, 2'd0, 32'd100, 0, '0);
    cyc(1, 4'd6, 2'd0, 32'd150, 0, '0);
    cyc(1, 4'd7, 2'd0, 32'd9, 1, '0);
    n_tests++; if (tafl !== 8'd150 || taem !== 8'd4) begin
      n_fail++; $display("FAIL buf_last_wins tafl %0d taem %0d want 150/4", tafl, taem); end
    idle_cycles(1, 1);
    n_tests++; if (taem !== 8'd9) begin n_fail++; $display("FAIL taem_commit got %0d want 9", taem); end
  endtask

  task automatic test_tfwr();
    cyc(1, 4'd4, 2'd1, 32'h113, 0, '0);
    idle_cycles(1, 0);
    n_tests++; if (strfwd !== 3'b000 || tfwr !== 24'h0) begin
      n_fail++; $display("FAIL tfwr_hold sf %b tfwr %h want 000/000000", strfwd, tfwr); end
    idle_cycles(1, 1);
    n_tests++; if (strfwd !== 3'b010 || tfwr !== 24'h00_98_00) begin
      n_fail++; $display("FAIL tfwr_commit sf %b tfwr %h want 010/009800", strfwd, tfwr); end
  endtask

  task automatic test_tdsr_tdar();
    cyc(1, 4'd3, 2'd2, 32'h1234_5677, 0, '0);
    n_tests++; if (tdsr[95:64] !== 32'h1234_5670) begin
      n_fail++; $display("FAIL tdsr_write got %h want 12345670", tdsr[95:64]); end
    cyc(1, 4'd9, 2'd2, 32'h0, 0, '0);
    n_tests++; if (tdar !== 3'b100) begin n_fail++; $display("FAIL tdar_set got %b want 100", tdar); end
    cyc(1, 4'd3, 2'd2, 32'hDEAD_BEE8, 0, '0);
    n_tests++; if (tdsr[95:64] !== 32'h1234_5670) begin
      n_fail++; $display("FAIL tdsr_locked got %h want 12345670", tdsr[95:64]); end
    cyc(1, 4'd9, 2'd2, 32'h0, 0, 3'b100);
    n_tests++; if (tdar !== 3'b100) begin n_fail++; $display("FAIL tdar_set_wins got %b want 100", tdar); end
    cyc(0, 4'd0, 2'd0, 32'h0, 0, 3'b100);
    n_tests++; if (tdar !== 3'b000) begin n_fail++; $display("FAIL tdar_clr got %b want 000", tdar); end
    cyc(1, 4'd3, 2'd2, 32'hDEAD_BEE8, 0, '0);
    n_tests++; if (tdsr[95:64] !== 32'hDEAD_BEE8) begin
      n_fail++; $display("FAIL tdsr_unlocked got %h want deadbee8", tdsr[95:64]); end
    n_tests++; if (tdsr[63:0] !== '0) begin n_fail++; $display("FAIL tdsr_others got %h want 0", tdsr[63:0]); end
  endtask

  task automatic test_qsel_oob();
    logic [NQ*32-1:0] t0 = tdsr;
    logic [NQ*8-1:0]  f0 = tfwr;
    logic [NQ-1:0]    s0 = strfwd, d0 = tdar;
    cyc(1, 4'd3, 2'd3, 32'hCAFE_F00D, 0, '0);
    cyc(1, 4'd4, 2'd3, 32'h11F, 0, '0);
    cyc(1, 4'd9, 2'd3, 32'h1, 0, '0);
    cyc(1, 4'd12, 2'd0, 32'hFFFF_FFFF, 1, '0);
    idle_cycles(1, 1);
    n_tests++; if (tdsr !== t0 || tfwr !== f0 || strfwd !== s0 || tdar !== d0 || cfg_pending !== 1'b0) begin
      n_fail++; $display("FAIL qsel_oob tdsr %h tfwr %h sf %b tdar %b pend %b want unchanged", tdsr, tfwr, strfwd, tdar, cfg_pending); end
  endtask

  // Write during a commit cycle stays pending; reset discards pending.
  task automatic test_commit_and_reset();
    cyc(1, 4'd5, 2'd0, 32'h55, 1, '0);
    n_tests++; if (tsem !== 8'h33 || cfg_pending !== 1'b1) begin
      n_fail++; $display("FAIL tsem_same_cycle tsem %h pend %b want 33/1", tsem, cfg_pending); end
    idle_cycles(1, 1);
    n_tests++; if (tsem !== 8'h55) begin n_fail++; $display("FAIL tsem_next_idle got %h want 55", tsem); end
    cyc(1, 4'd5, 2'd0, 32'h77, 0, '0);
    rst_n = 0; idle_cycles(1, 1); rst_n = 1;
    idle_cycles(2, 1);
    n_tests++; if (tsem !== 8'h00 || cfg_pending !== 1'b0) begin
      n_fail++; $display("FAIL reset_discard tsem %h pend %b want 00/0", tsem, cfg_pending); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [NQ-1:0] clr = ($urandom_range(0, 7) == 0) ? NQ'($urandom) : '0;
      cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 2'($urandom),
          ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 300)),
          $urandom_range(0, 2) == 0, clr);
      n_tests++; if (palr !== m_palr || paur !== {m_paur, 16'h8808} || opd !== {16'h0001, m_opd}) begin
        n_fail++; $display("FAIL rnd_imm cyc %0d palr %h paur %h opd %h want %h %h %h", n, palr, paur, opd,
                           m_palr, {m_paur, 16'h8808}, {16'h0001, m_opd}); end
      n_tests++; if (tdsr !== exp_tdsr() || tdar !== exp_tdar()) begin
        n_fail++; $display("FAIL rnd_q cyc %0d tdsr %h tdar %b want %h %b", n, tdsr, tdar, exp_tdsr(), exp_tdar()); end
      n_tests++; if (tfwr !== exp_tfwr() || strfwd !== exp_sf()) begin
        n_fail++; $display("FAIL rnd_tfwr cyc %0d tfwr %h sf %b want %h %b", n, tfwr, strfwd, exp_tfwr(), exp_sf()); end
      n_tests++; if (tsem !== m_a[0] || tafl !== m_a[1] || taem !== m_a[2] || tipg !== exp_tipg()) begin
        n_fail++; $display("FAIL rnd_cfg cyc %0d %h %h %h %h want %h %h %h %h", n, tsem, tafl, taem, tipg,
                           m_a[0], m_a[1], m_a[2], exp_tipg()); end
      n_tests++; if (cfg_pending !== exp_pend()) begin
        n_fail++; $display("FAIL rnd_pend cyc %0d got %b want %b", n, cfg_pending, exp_pend()); end
    end
  endtask

  initial begin
    rst_n = 0; reg_wen = 0; reg_widx = '0; reg_qsel = '0; reg_wdata = '0;
    tx_idle = 0; tdar_clr = '0;
    model_reset();
    test_reset();
    test_buffered();
    test_tfwr();
    test_tdsr_tdar();
    test_qsel_oob();
    test_commit_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
